dmem_responder: RTL and testbench

- Data-memory responder (slave) for the core's MEM-stage load/store requests.
- Accepts one request per valid/ready handshake and models a configurable number of wait states.
- Performs byte/half/word stores with lane masking, and returns loads sign- or zero-extended per the RV32I funct3 width code.
- Sits behind mem_stage and drives the MEM-stage stall source while a transaction is in flight.

---
 rtl/dmem_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage load/store requests: one request per handshake,
// LATENCY wait states, lane-masked stores and sign/zero-extended loads.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_width_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAST  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               write_q, write_d;
  logic [2:0]         width_q, width_d;
  logic [1:0]         lane_q, lane_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;

  logic [31:0]        off;
  logic               req_oor;
  logic               req_err;
  logic               accept;
  logic               enter_resp;

  logic               cur_write;
  logic [2:0]         cur_width;
  logic [1:0]         cur_lane;
  logic [IDX_W-1:0]   cur_idx;
  logic [31:0]        cur_wdata;
  logic               cur_err;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        mem_word;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wlanes;
  logic               mem_we;

  // Rejects illegal widths, stores of unsigned widths, misalignment and out-of-range.
  function automatic logic req_error(input logic wr, input logic [2:0] w,
                                     input logic [1:0] a_lo, input logic oor);
    logic e;
    case (w)
      3'b000:  e = 1'b0;
      3'b100:  e = wr;
      3'b001:  e = a_lo[0];
      3'b101:  e = wr | a_lo[0];
      3'b010:  e = (a_lo != 2'b00);
      default: e = 1'b1;
    endcase
    return e | oor;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] w);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {lane, 3'b000};
    case (w)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b100:  r = {24'h0, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b101:  r = {16'h0, s[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    off     = req_addr_i - ADDR_BASE;
    req_oor = ({1'b0, off} >= LIMIT);
    req_err = req_error(req_write_i, req_width_i, req_addr_i[1:0], req_oor);
    accept  = req_valid_i && (state_q == S_IDLE);
  end

  // With LATENCY=0 the commit edge is the accept edge, so the live request is used.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_write = req_write_i;
      cur_width = req_width_i;
      cur_lane  = req_addr_i[1:0];
      cur_idx   = off[IDX_W+1:2];
      cur_wdata = req_wdata_i;
      cur_err   = req_err;
    end else begin
      cur_write = write_q;
      cur_width = width_q;
      cur_lane  = lane_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_err   = err_q;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
          cnt_d   = 4'd0;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST) state_d = S_RESP;
        else               cnt_d   = cnt_q + 4'd1;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  end

  // Output logic
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    rsp_valid_o = (state_q == S_RESP);
    rsp_rdata_o = rsp_rdata_q;
    rsp_err_o   = rsp_err_q;
  end

  always_comb begin
    write_d = write_q;
    width_d = width_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (accept) begin
      write_d = req_write_i;
      width_d = req_width_i;
      lane_d  = req_addr_i[1:0];
      idx_d   = off[IDX_W+1:2];
      wdata_d = req_wdata_i;
      err_d   = req_err;
    end
  end

  always_ff @(posedge clk_i) begin
    write_q <= write_d;
    width_q <= width_d;
    lane_q  <= lane_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    err_q   <= err_d;
  end

  always_comb begin
    mem_word = mem[cur_idx];
    case (cur_width[1:0])
      2'b00: begin
        mem_be     = 4'b0001 << cur_lane;
        mem_wlanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        mem_be     = cur_lane[1] ? 4'b1100 : 4'b0011;
        mem_wlanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        mem_be     = 4'b1111;
        mem_wlanes = cur_wdata;
      end
    endcase
    mem_we = enter_resp && cur_write && !cur_err && !rst_i;
  end

  // Response data is captured on the edge entering RESP and cleared once consumed.
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (enter_resp) begin
      rsp_err_d   = cur_err;
      rsp_rdata_d = (cur_err || cur_write) ? 32'h0 : load_extend(mem_word, cur_lane, cur_width);
    end else if ((state_q == S_RESP) && rsp_ready_i) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[cur_idx][8*i +: 8] <= mem_wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for the main sequence,
// LATENCY=0 instance for the zero-wait-state path.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [2:0]  req_width = 3'b010;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b1;
  logic [31:0] z_req_addr = 32'h0, z_req_wdata = 32'h0;
  logic [2:0]  z_req_width = 3'b010;
  logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;

  int tests  = 0;
  int failed = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_width_i(req_width),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_write_i(z_req_write),
    .req_addr_i(z_req_addr), .req_wdata_i(z_req_wdata), .req_width_i(z_req_width),
    .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready), .rsp_rdata_o(z_rsp_rdata),
    .rsp_err_o(z_rsp_err), .busy_o(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction on the LATENCY=2 instance; inputs are scrambled after acceptance.
  task automatic txn(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] w, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_write = wr; req_addr = a; req_wdata = d; req_width = w; req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = $urandom;
    req_width = 3'b111; req_write = ~wr;
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    tick;
  endtask

  initial begin
    int n;
    tick;
    tick;
    chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    tick;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);

    txn("sw10", 1'b1, 32'h10, 32'h80F0_7F81, 3'b010, 32'h0, 1'b0);
    txn("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'h80F0_7F81, 1'b0);
    txn("lb10", 1'b0, 32'h10, 32'h0, 3'b000, 32'hFFFF_FF81, 1'b0);
    txn("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h0000_0080, 1'b0);
    txn("lh12", 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_80F0, 1'b0);
    txn("lhu10", 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000_7F81, 1'b0);

    txn("sb11", 1'b1, 32'h11, 32'hDEAD_BEAA, 3'b000, 32'h0, 1'b0);
    txn("sh12", 1'b1, 32'h12, 32'h0000_1234, 3'b001, 32'h0, 1'b0);
    txn("lw10_merge", 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234_AA81, 1'b0);

    txn("err_lh11", 1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1);
    txn("err_sw12", 1'b1, 32'h12, 32'hFFFF_FFFF, 3'b010, 32'h0, 1'b1);
    txn("err_lw_oor", 1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1);
    txn("err_sbu", 1'b1, 32'h10, 32'hFFFF_FFFF, 3'b100, 32'h0, 1'b1);
    txn("lw10_after_err", 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234_AA81, 1'b0);

    // Backpressure: response must hold while rsp_ready is low.
    req_write = 1'b0; req_addr = 32'h10; req_width = 3'b010; req_valid = 1'b1;
    rsp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick;
      n++;
    end
    chk("bp_lat", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rdata", rsp_rdata, 32'h1234_AA81);
      chk("bp_ready", {31'h0, req_ready}, 32'h0);
      chk("bp_busy", {31'h0, busy}, 32'h1);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    chk("bp_done_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_done_busy", {31'h0, busy}, 32'h0);
    chk("bp_done_valid", {31'h0, rsp_valid}, 32'h0);

    // Reset during WAIT discards the uncommitted store.
    txn("sw20_prior", 1'b1, 32'h20, 32'hCAFE_0001, 3'b010, 32'h0, 1'b0);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1111_1111; req_width = 3'b010;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    chk("mid_busy_pre", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #2;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_err", {31'h0, rsp_err}, 32'h0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    txn("lw20_after_rst", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFE_0001, 1'b0);

    // Zero wait states: response in the cycle after acceptance.
    z_req_write = 1'b1; z_req_addr = 32'h4; z_req_wdata = 32'hA5A5_5A5A; z_req_width = 3'b010;
    z_req_valid = 1'b1; z_rsp_ready = 1'b1;
    tick;
    z_req_valid = 1'b0;
    chk("z_sw_valid", {31'h0, z_rsp_valid}, 32'h1);
    chk("z_sw_err", {31'h0, z_rsp_err}, 32'h0);
    chk("z_sw_rdata", z_rsp_rdata, 32'h0);
    tick;
    chk("z_idle_ready", {31'h0, z_req_ready}, 32'h1);
    z_req_write = 1'b0; z_req_addr = 32'h6; z_req_width = 3'b101; z_req_valid = 1'b1;
    tick;
    z_req_valid = 1'b0;
    chk("z_lhu_valid", {31'h0, z_rsp_valid}, 32'h1);
    chk("z_lhu_rdata", z_rsp_rdata, 32'h0000_A5A5);
    tick;
    z_req_addr = 32'h4; z_req_width = 3'b000; z_req_valid = 1'b1;
    tick;
    z_req_valid = 1'b0;
    chk("z_lb_rdata", z_rsp_rdata, 32'h0000_005A);
    tick;
    chk("z_busy_end", {31'h0, z_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
